reg_wr_arbiter: RTL and testbench
=================================

Name: reg_wr_arbiter

Overview:
- Write-port arbiter directly upstream of the per-thread register file (16 registers per thread, one write port).
- Collects write requests from four producers:
  - memory load path (source 0);
  - three CPU result paths (sources 1..3).
- Grants at most one request per cycle with valid/ready handshakes.
- Drives the register file's write controls with registered outputs: mem_wr_en, wr_en, reg_din_select, wr_addr, wr_thread_num and the four data buses.

Parameters:
- WIDTH, 16, data width of every source and output bus.
- N_THREADS, `N_THREADS, number of hardware threads.
- N_THREADS_MSB, `MSB(N_THREADS-1), MSB of thread-number fields.
- MEM_BURST_MAX, 4, maximum consecutive memory grants while any CPU source is waiting (range 1..15).

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_hold  in  1  when high, no grant is issued this cycle.
- mem_valid  in  1  source 0 request.
- mem_ready  out  1  source 0 granted (combinational).
- mem_data  in  WIDTH  source 0 data.
- mem_addr  in  `REG_ADDR_MSB+1  source 0 register address.
- mem_thread  in  N_THREADS_MSB+1  source 0 thread number.
- src_valid  in  3  requests of sources 1..3 (bit i-1 = source i).
- src_ready  out  3  grants of sources 1..3 (combinational).
- src_data  in  3*WIDTH  data; source i in bits [i*WIDTH-1 -: WIDTH].
- src_addr  in  3*(`REG_ADDR_MSB+1)  register addresses, packed likewise.
- src_thread  in  3*(N_THREADS_MSB+1)  thread numbers, packed likewise.
- mem_dout, dout1, dout2, dout3  out  WIDTH each  registered data of the last grant for each source.
- reg_din_select  out  2  0 = memory, 1..3 = CPU source.
- mem_wr_en  out  1  registered write strobe for a memory grant.
- wr_en  out  1  registered write strobe for a CPU-source grant.
- wr_addr  out  `REG_ADDR_MSB+1  registered write address.
- wr_thread_num  out  N_THREADS_MSB+1  registered write thread.

Behaviour:
- Reset (async assert, sync release): all outputs 0, burst_cnt=0, rr_last=3 so that source 1 is first in round-robin order.
- Handshake:
  - transfer occurs when a source's valid and ready are both high in the same cycle;
  - at most one ready bit (mem_ready plus src_ready) is high per cycle;
  - ready is never high without the matching valid;
  - wr_hold=1 forces all ready low;
  - valid must stay high with data stable until the transfer; the arbiter does not check this.
- Grant decision, evaluated each cycle with wr_hold=0:
  - Let cpu_req = |src_valid.
  - If mem_valid and (burst_cnt < MEM_BURST_MAX or !cpu_req): grant memory.
  - Else if cpu_req: grant the first valid source in order rr_last+1, rr_last+2, ... modulo 3 over {1,2,3}.
  - Else: no grant.
- burst_cnt:
  - on a memory grant with cpu_req=1: increment, saturating at MEM_BURST_MAX;
  - on a memory grant with cpu_req=0: unchanged;
  - on a CPU grant: set to 0, and rr_last <= granted index;
  - on an idle cycle (no valid, or wr_hold=1): set to 0.
- Output latency: exactly 1 cycle. In the cycle after a grant:
  - mem_wr_en=1 for a memory grant, or wr_en=1 for a CPU grant; never both;
  - reg_din_select = granted index;
  - wr_addr and wr_thread_num come from the granted source;
  - the granted source's dout register is loaded; the other dout registers hold their value.
- No grant: mem_wr_en=wr_en=0; reg_din_select, wr_addr, wr_thread_num and all dout registers hold their value.
- Throughput: one write per cycle sustained; no bubbles between back-to-back grants.
- Reset mid-operation: any pending output write is dropped; in-flight valid requests are re-arbitrated after release.

Test Plan:
- Reset: hold rst_n=0 with all valids high -> all readies 0 and all outputs 0; first cycle after release, mem_ready=1 and burst_cnt becomes 1.
- Round-robin: src_valid=3'b111 held, mem_valid=0 -> grants 1,2,3,1,2,3 on consecutive cycles; wr_en=1 each following cycle, reg_din_select 1,2,3,...; dout1/2/3 carry data values 0x1111/0x2222/0x3333.
- Memory burst limit: mem_valid=1 and src_valid=3'b010 held, MEM_BURST_MAX=4 -> grants mem,mem,mem,mem,src2,mem,... (4 memory grants, then 1 CPU grant); mem_wr_en and wr_en never high in the same cycle.
- Memory alone: mem_valid=1 for 10 cycles, src_valid=0 -> 10 consecutive memory grants; mem_wr_en high cycles 1..10 after start; wr_addr/wr_thread_num track the inputs with 1-cycle lag.
- wr_hold: assert wr_hold for 2 cycles mid-stream with all valids high -> all readies 0 and both strobes 0 one cycle later; burst_cnt=0; round-robin resumes from the source after rr_last.
- Async reset mid-burst: drop rst_n between clock edges during grants -> all outputs clear immediately without waiting for a clock edge; after release, round-robin restarts at source 1.

Source files
------------

// File: rtl/reg_wr_arbiter_if.sv
// reg_wr_arbiter_if
//   Bundles everything between the write producers, the arbiter and the
//   per-thread register file write port.
//
//   Handshake (valid/ready): a producer raises *_valid with its data, address
//   and thread held stable; the transfer happens in the cycle where its
//   valid and ready are both high. Ready is combinational, never high without
//   the matching valid, and at most one ready bit is high per cycle.
//
//   Modports:
//     slave  - the arbiter: takes requests, drives readies and write controls.
//     master - the producer/register-file side (used by the testbench).
//   Packing: source i (1..3) of src_* occupies bits [i*W-1 -: W].
`ifndef REG_ADDR_MSB
`define REG_ADDR_MSB 3
`endif

interface reg_wr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int TW    = 2,
  parameter int AW    = `REG_ADDR_MSB + 1
);
  logic               wr_hold;
  logic               mem_valid;
  logic               mem_ready;
  logic [WIDTH-1:0]   mem_data;
  logic [AW-1:0]      mem_addr;
  logic [TW-1:0]      mem_thread;
  logic [2:0]         src_valid;
  logic [2:0]         src_ready;
  logic [3*WIDTH-1:0] src_data;
  logic [3*AW-1:0]    src_addr;
  logic [3*TW-1:0]    src_thread;
  logic [WIDTH-1:0]   mem_dout;
  logic [WIDTH-1:0]   dout1;
  logic [WIDTH-1:0]   dout2;
  logic [WIDTH-1:0]   dout3;
  logic [1:0]         reg_din_select;
  logic               mem_wr_en;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [TW-1:0]      wr_thread_num;
  logic [3:0]         dbg_burst_cnt;
  logic [1:0]         dbg_rr_last;

  modport slave (
    input  wr_hold, mem_valid, mem_data, mem_addr, mem_thread,
           src_valid, src_data, src_addr, src_thread,
    output mem_ready, src_ready, mem_dout, dout1, dout2, dout3,
           reg_din_select, mem_wr_en, wr_en, wr_addr, wr_thread_num,
           dbg_burst_cnt, dbg_rr_last
  );

  modport master (
    output wr_hold, mem_valid, mem_data, mem_addr, mem_thread,
           src_valid, src_data, src_addr, src_thread,
    input  mem_ready, src_ready, mem_dout, dout1, dout2, dout3,
           reg_din_select, mem_wr_en, wr_en, wr_addr, wr_thread_num,
           dbg_burst_cnt, dbg_rr_last
  );
endinterface

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter
//   Single write-port arbiter in front of the per-thread register file.
//   Source 0 is the memory load path, sources 1..3 are CPU result paths.
//   Memory wins unless it has taken MEM_BURST_MAX consecutive grants while a
//   CPU source waits; CPU sources are served round-robin. All register file
//   controls are registered (1-cycle latency, one write per cycle sustained).
//
//   Ports:
//     CLK    - clock
//     rst_n  - asynchronous active-low reset
//     bus    - reg_wr_arbiter_if.slave: requests, readies, write controls,
//              plus dbg_burst_cnt / dbg_rr_last exposing the arbiter state.
`ifndef REG_ADDR_MSB
`define REG_ADDR_MSB 3
`endif

module reg_wr_arbiter #(
  parameter int WIDTH         = 16,
  parameter int N_THREADS     = 4,
  parameter int N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0,
  parameter int MEM_BURST_MAX = 4
) (
  input  logic CLK,
  input  logic rst_n,
  reg_wr_arbiter_if.slave bus
);
  localparam int AW = `REG_ADDR_MSB + 1;
  localparam int TW = N_THREADS_MSB + 1;
  localparam logic [3:0] BURST_MAX = 4'(MEM_BURST_MAX);

  // Arbiter state
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic [1:0]       rr_last_q, rr_last_d;

  // Registered write controls
  logic             mem_wr_en_q, mem_wr_en_d;
  logic             wr_en_q, wr_en_d;
  logic [1:0]       sel_q, sel_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [TW-1:0]    thr_q, thr_d;
  logic [WIDTH-1:0] dout_q [4];
  logic [WIDTH-1:0] dout_d [4];

  // Per-source views, index 0 = memory, 1..3 = CPU sources
  logic [WIDTH-1:0] din_a  [4];
  logic [AW-1:0]    addr_a [4];
  logic [TW-1:0]    thr_a  [4];

  logic             cpu_req;
  logic [1:0]       cpu_idx;
  logic             mem_grant;
  logic             cpu_grant;
  logic             any_grant;
  logic [1:0]       grant_idx;

  always_comb begin
    din_a[0]  = bus.mem_data;
    addr_a[0] = bus.mem_addr;
    thr_a[0]  = bus.mem_thread;
    for (int i = 1; i < 4; i++) begin
      din_a[i]  = bus.src_data[i*WIDTH-1 -: WIDTH];
      addr_a[i] = bus.src_addr[i*AW-1 -: AW];
      thr_a[i]  = bus.src_thread[i*TW-1 -: TW];
    end
  end

  // Round-robin pick: scan rr_last+1, rr_last+2, rr_last+3 (mod 3 over 1..3).
  // The scan runs from lowest to highest priority so the last hit wins.
  always_comb begin
    logic [1:0] cand;
    cpu_idx = 2'd0;
    cand    = 2'd1;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'(((int'(rr_last_q) + k - 1) % 3) + 1);
      if (bus.src_valid[cand - 2'd1]) cpu_idx = cand;
    end
  end

  // Grants are gated by rst_n so no ready escapes while reset is asserted.
  always_comb begin
    cpu_req   = |bus.src_valid;
    mem_grant = rst_n && !bus.wr_hold && bus.mem_valid &&
                ((burst_cnt_q < BURST_MAX) || !cpu_req);
    cpu_grant = rst_n && !bus.wr_hold && !mem_grant && cpu_req;
    any_grant = mem_grant || cpu_grant;
    grant_idx = mem_grant ? 2'd0 : cpu_idx;
  end

  // Next-state logic
  always_comb begin
    burst_cnt_d = 4'd0;
    rr_last_d   = rr_last_q;
    if (mem_grant) begin
      // The burst only counts while a CPU source is actually being held off.
      if (cpu_req)
        burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
      else
        burst_cnt_d = burst_cnt_q;
    end else if (cpu_grant) begin
      rr_last_d = cpu_idx;
    end

    mem_wr_en_d = mem_grant;
    wr_en_d     = cpu_grant;
    sel_d       = any_grant ? grant_idx         : sel_q;
    addr_d      = any_grant ? addr_a[grant_idx] : addr_q;
    thr_d       = any_grant ? thr_a[grant_idx]  : thr_q;
    for (int i = 0; i < 4; i++)
      dout_d[i] = (any_grant && (grant_idx == 2'(i))) ? din_a[i] : dout_q[i];
  end

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= 4'd0;
      rr_last_q   <= 2'd3;
      mem_wr_en_q <= 1'b0;
      wr_en_q     <= 1'b0;
      sel_q       <= 2'd0;
      addr_q      <= '0;
      thr_q       <= '0;
      for (int i = 0; i < 4; i++) dout_q[i] <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rr_last_q   <= rr_last_d;
      mem_wr_en_q <= mem_wr_en_d;
      wr_en_q     <= wr_en_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      thr_q       <= thr_d;
      for (int i = 0; i < 4; i++) dout_q[i] <= dout_d[i];
    end
  end

  // Outputs
  always_comb begin
    bus.mem_ready      = mem_grant;
    bus.src_ready      = cpu_grant ? (3'b001 << (cpu_idx - 2'd1)) : 3'b000;
    bus.mem_wr_en      = mem_wr_en_q;
    bus.wr_en          = wr_en_q;
    bus.reg_din_select = sel_q;
    bus.wr_addr        = addr_q;
    bus.wr_thread_num  = thr_q;
    bus.mem_dout       = dout_q[0];
    bus.dout1          = dout_q[1];
    bus.dout2          = dout_q[2];
    bus.dout3          = dout_q[3];
    bus.dbg_burst_cnt  = burst_cnt_q;
    bus.dbg_rr_last    = rr_last_q;
  end
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb_reg_wr_arbiter
//   Directed bench for reg_wr_arbiter. Inputs change on the falling edge,
//   readies are checked 1 time unit later, registered outputs on the next
//   falling edge.
module tb_reg_wr_arbiter;
  localparam int WIDTH = 16;
  localparam int TW    = 2;
  localparam int AW    = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected registered outputs (hold across idle cycles)
  logic [1:0]       e_sel;
  logic [AW-1:0]    e_addr;
  logic [TW-1:0]    e_thr;
  logic [WIDTH-1:0] e_dout [4];

  reg_wr_arbiter_if #(.WIDTH(WIDTH), .TW(TW), .AW(AW)) bus ();

  reg_wr_arbiter #(.WIDTH(WIDTH), .N_THREADS(4), .MEM_BURST_MAX(4)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic mem_en, input logic en);
    check({tag, "/mem_wr_en"}, bus.mem_wr_en, mem_en);
    check({tag, "/wr_en"}, bus.wr_en, en);
    check({tag, "/sel"}, bus.reg_din_select, e_sel);
    check({tag, "/wr_addr"}, bus.wr_addr, e_addr);
    check({tag, "/wr_thread"}, bus.wr_thread_num, e_thr);
    check({tag, "/mem_dout"}, bus.mem_dout, e_dout[0]);
    check({tag, "/dout1"}, bus.dout1, e_dout[1]);
    check({tag, "/dout2"}, bus.dout2, e_dout[2]);
    check({tag, "/dout3"}, bus.dout3, e_dout[3]);
  endtask

  // One cycle: exp_g = -1 no grant, 0 memory, 1..3 CPU source.
  task automatic cycle(input string tag, input int exp_g);
    logic [2:0] exp_sr;
    #1;
    exp_sr = (exp_g >= 1) ? 3'(1 << (exp_g - 1)) : 3'b000;
    check({tag, "/mem_ready"}, bus.mem_ready, (exp_g == 0));
    check({tag, "/src_ready"}, bus.src_ready, exp_sr);
    if (exp_g == 0) begin
      e_sel     = 2'd0;
      e_addr    = bus.mem_addr;
      e_thr     = bus.mem_thread;
      e_dout[0] = bus.mem_data;
    end else if (exp_g > 0) begin
      e_sel         = 2'(exp_g);
      e_addr        = bus.src_addr[exp_g*AW-1 -: AW];
      e_thr         = bus.src_thread[exp_g*TW-1 -: TW];
      e_dout[exp_g] = bus.src_data[exp_g*WIDTH-1 -: WIDTH];
    end
    @(negedge clk);
    check_outputs(tag, (exp_g == 0), (exp_g > 0));
  endtask

  task automatic clear_exp();
    e_sel  = '0;
    e_addr = '0;
    e_thr  = '0;
    for (int i = 0; i < 4; i++) e_dout[i] = '0;
  endtask

  initial begin
    clear_exp();
    rst_n          = 1'b0;
    bus.wr_hold    = 1'b0;
    bus.mem_valid  = 1'b1;
    bus.mem_data   = 16'hAAAA;
    bus.mem_addr   = 4'd5;
    bus.mem_thread = 2'd1;
    bus.src_valid  = 3'b111;
    bus.src_data   = {16'h3333, 16'h2222, 16'h1111};
    bus.src_addr   = {4'hC, 4'hB, 4'hA};
    bus.src_thread = {2'd3, 2'd2, 2'd1};

    // Reset held with every request active
    repeat (2) @(negedge clk);
    check("rst/mem_ready", bus.mem_ready, 1'b0);
    check("rst/src_ready", bus.src_ready, 3'b000);
    check("rst/burst", bus.dbg_burst_cnt, 4'd0);
    check("rst/rr_last", bus.dbg_rr_last, 2'd3);
    check_outputs("rst", 1'b0, 1'b0);

    // Release: memory granted first, burst counts because CPU is waiting
    rst_n = 1'b1;
    cycle("rst_rel", 0);
    check("rst_rel/burst", bus.dbg_burst_cnt, 4'd1);

    // Round-robin over the three CPU sources
    bus.mem_valid = 1'b0;
    for (int k = 0; k < 6; k++) cycle($sformatf("rr%0d", k), (k % 3) + 1);
    check("rr/burst", bus.dbg_burst_cnt, 4'd0);
    check("rr/rr_last", bus.dbg_rr_last, 2'd3);

    // Memory burst limit against a waiting source 2
    bus.mem_valid = 1'b1;
    bus.src_valid = 3'b010;
    for (int k = 0; k < 4; k++) cycle($sformatf("burst_mem%0d", k), 0);
    check("burst/cnt_sat", bus.dbg_burst_cnt, 4'd4);
    cycle("burst_src2", 2);
    check("burst/cnt_clr", bus.dbg_burst_cnt, 4'd0);
    cycle("burst_mem_again", 0);
    check("burst/cnt_one", bus.dbg_burst_cnt, 4'd1);

    // Memory alone: ten back-to-back grants, address/thread tracking
    bus.src_valid = 3'b000;
    for (int k = 0; k < 10; k++) begin
      bus.mem_addr   = 4'(k);
      bus.mem_thread = 2'(k);
      bus.mem_data   = 16'h0100 + 16'(k);
      cycle($sformatf("memonly%0d", k), 0);
    end
    check("memonly/burst_hold", bus.dbg_burst_cnt, 4'd1);
    bus.mem_valid = 1'b0;
    cycle("idle", -1);
    check("idle/burst", bus.dbg_burst_cnt, 4'd0);

    // wr_hold mid-stream
    bus.src_valid = 3'b111;
    cycle("hold_pre_src3", 3);
    bus.mem_valid = 1'b1;
    bus.wr_hold   = 1'b1;
    cycle("hold0", -1);
    cycle("hold1", -1);
    check("hold/burst", bus.dbg_burst_cnt, 4'd0);
    check("hold/rr_last", bus.dbg_rr_last, 2'd3);
    bus.wr_hold   = 1'b0;
    bus.mem_valid = 1'b0;
    cycle("hold_post_src1", 1);
    cycle("hold_post_src2", 2);

    // Async reset between edges while a write is pending on the outputs
    #2;
    rst_n = 1'b0;
    #1;
    clear_exp();
    check("areset/rr_last", bus.dbg_rr_last, 2'd3);
    check("areset/src_ready", bus.src_ready, 3'b000);
    check_outputs("areset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("areset_src1", 1);
    cycle("areset_src2", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
